// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO over a register-file array.
// Flags and occupancy are registered from the next-count value; error pulses last one cycle.
module sync_fifo #(
  parameter int data_width = 8,
  parameter int addr_width = 2,
  parameter int af_level   = 3,
  parameter int ae_level   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [data_width-1:0] w_data,
  input  logic                  rd,
  output logic [data_width-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int depth = 1 << addr_width;
  localparam logic [addr_width:0]   depth_c = (addr_width + 1)'(depth);
  localparam logic [addr_width:0]   af_c    = (addr_width + 1)'(af_level);
  localparam logic [addr_width:0]   ae_c    = (addr_width + 1)'(ae_level);
  localparam logic [addr_width:0]   cnt_one = (addr_width + 1)'(1);
  localparam logic [addr_width-1:0] ptr_one = (addr_width)'(1);

  logic [data_width-1:0] mem [depth];
  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;
  logic [addr_width:0]   count_next;

  // A push into a full FIFO is accepted when a pop frees the head slot that same cycle.
  assign push_ok = wr & (~full | rd);
  assign pop_ok  = rd & ~empty;
  assign r_data  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + cnt_one;
    end else if (!push_ok && pop_ok) begin
      count_next = count - cnt_one;
    end
  end

  // Storage has no reset; only writes gated by an accepted push touch it.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ptr_one;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ptr_one;
      end
      count        <= count_next;
      full         <= (count_next == depth_c);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= af_c);
      almost_empty <= (count_next <= ae_c);
      overflow     <= wr & ~push_ok;
      underflow    <= rd & ~pop_ok;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus a randomized run
// compared against a queue-based reference of FIFO contents.
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int passed = 0;

  // Reference: FIFO contents as a queue, plus expected error pulses for the last cycle.
  logic [7:0] exp_q[$];
  logic       exp_ovf;
  logic       exp_unf;

  sync_fifo #(
    .data_width(8),
    .addr_width(2),
    .af_level  (3),
    .ae_level  (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .w_data      (w_data),
    .rd          (rd),
    .r_data      (r_data),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one clock cycle of wr/rd/w_data, then advance the reference model.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    int  n;
    bit  push_ok;
    bit  pop_ok;
    n       = exp_q.size();
    push_ok = w && ((n < 4) || r);
    pop_ok  = r && (n > 0);
    wr      = w;
    rd      = r;
    w_data  = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
    if (pop_ok)  void'(exp_q.pop_front());
    if (push_ok) exp_q.push_back(d);
    exp_ovf = w && !push_ok;
    exp_unf = r && !pop_ok;
  endtask

  task automatic do_reset(input logic w, input logic r);
    reset = 1'b1;
    wr    = w;
    rd    = r;
    w_data = 8'hEE;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    do_reset(1'b0, 1'b0);
    checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
    checks++; if ({empty, almost_empty, full, almost_full} !== 4'b1100)
      $display("FAIL reset_flags got e/ae/f/af=%b want 1100", {empty, almost_empty, full, almost_full});
    else passed++;
    cycle(1'b0, 1'b0, 8'h00);
    checks++; if ({overflow, underflow, empty, count} !== {1'b0, 1'b0, 1'b1, 3'd0})
      $display("FAIL idle_state got ovf=%b unf=%b empty=%b count=%0d want 0 0 1 0", overflow, underflow, empty, count);
    else passed++;
  endtask

  task automatic test_fill();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, vals[i]);
      checks++; if (count !== 3'(i + 1)) $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); else passed++;
      checks++; if (almost_full !== (i + 1 >= 3)) $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, (i + 1 >= 3)); else passed++;
      checks++; if (full !== (i + 1 == 4)) $display("FAIL fill_full[%0d] got %b want %b", i, full, (i + 1 == 4)); else passed++;
      checks++; if (almost_empty !== (i + 1 <= 1)) $display("FAIL fill_ae[%0d] got %b want %b", i, almost_empty, (i + 1 <= 1)); else passed++;
      checks++; if (r_data !== 8'h11) $display("FAIL fill_head[%0d] got %h want 11", i, r_data); else passed++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    cycle(1'b1, 1'b0, 8'h55);
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_pulse got %b want 1", overflow); else passed++;
    checks++; if (count !== 3'd4 || full !== 1'b1) $display("FAIL ovf_state got count=%0d full=%b want 4 1", count, full); else passed++;
    cycle(1'b0, 1'b0, 8'h00);
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", overflow); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (r_data !== vals[i]) $display("FAIL ovf_pop[%0d] got %h want %h", i, r_data, vals[i]); else passed++;
      cycle(1'b0, 1'b1, 8'h00);
    end
    checks++; if (empty !== 1'b1 || count !== 3'd0) $display("FAIL ovf_drained got empty=%b count=%0d want 1 0", empty, count); else passed++;
  endtask

  task automatic test_full_rw();
    logic [7:0] vals [4];
    vals = '{8'h22, 8'h33, 8'h44, 8'hA0};
    cycle(1'b1, 1'b0, 8'h11);
    cycle(1'b1, 1'b0, 8'h22);
    cycle(1'b1, 1'b0, 8'h33);
    cycle(1'b1, 1'b0, 8'h44);
    cycle(1'b1, 1'b1, 8'hA0);
    checks++; if (count !== 3'd4 || full !== 1'b1) $display("FAIL fullrw_state got count=%0d full=%b want 4 1", count, full); else passed++;
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL fullrw_pulses got ovf=%b unf=%b want 0 0", overflow, underflow); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (r_data !== vals[i]) $display("FAIL fullrw_pop[%0d] got %h want %h", i, r_data, vals[i]); else passed++;
      cycle(1'b0, 1'b1, 8'h00);
    end
    checks++; if (empty !== 1'b1) $display("FAIL fullrw_empty got %b want 1", empty); else passed++;
  endtask

  task automatic test_empty_rw();
    cycle(1'b1, 1'b1, 8'h77);
    checks++; if (underflow !== 1'b1) $display("FAIL emptyrw_unf got %b want 1", underflow); else passed++;
    checks++; if (count !== 3'd1 || empty !== 1'b0) $display("FAIL emptyrw_count got count=%0d empty=%b want 1 0", count, empty); else passed++;
    checks++; if (r_data !== 8'h77) $display("FAIL emptyrw_head got %h want 77", r_data); else passed++;
    cycle(1'b0, 1'b1, 8'h00);
    checks++; if (underflow !== 1'b0 || empty !== 1'b1) $display("FAIL emptyrw_pop got unf=%b empty=%b want 0 1", underflow, empty); else passed++;
    cycle(1'b0, 1'b1, 8'h00);
    checks++; if (underflow !== 1'b1 || count !== 3'd0) $display("FAIL rd_empty got unf=%b count=%0d want 1 0", underflow, count); else passed++;
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 8'h01);
    cycle(1'b1, 1'b0, 8'h02);
    cycle(1'b1, 1'b0, 8'h03);
    checks++; if (count !== 3'd3) $display("FAIL mid_pre got %0d want 3", count); else passed++;
    do_reset(1'b1, 1'b1);
    checks++; if (count !== 3'd0 || empty !== 1'b1 || almost_full !== 1'b0)
      $display("FAIL mid_reset got count=%0d empty=%b af=%b want 0 1 0", count, empty, almost_full);
    else passed++;
  endtask

  task automatic test_random();
    logic       w;
    logic       r;
    logic [7:0] d;
    int         n;
    for (int i = 0; i < 60; i++) begin
      w = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 45);
      d = 8'($urandom_range(0, 255));
      cycle(w, r, d);
      n = exp_q.size();
      checks++; if (count !== 3'(n)) $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, n); else passed++;
      checks++; if ({full, empty, almost_full, almost_empty} !== {n == 4, n == 0, n >= 3, n <= 1})
        $display("FAIL rnd_flags[%0d] got f/e/af/ae=%b want %b", i, {full, empty, almost_full, almost_empty},
                 {n == 4, n == 0, n >= 3, n <= 1});
      else passed++;
      checks++; if ({overflow, underflow} !== {exp_ovf, exp_unf})
        $display("FAIL rnd_pulses[%0d] got ovf/unf=%b want %b", i, {overflow, underflow}, {exp_ovf, exp_unf});
      else passed++;
      if (n > 0) begin
        checks++; if (r_data !== exp_q[0]) $display("FAIL rnd_head[%0d] got %h want %h", i, r_data, exp_q[0]); else passed++;
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    wr      = 1'b0;
    rd      = 1'b0;
    w_data  = 8'h00;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
